regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 8 x 16-bit register bank between NREQ write requesters (ALU writeback, load unit, immediate-move path).
- Picks one requester per cycle by round-robin and drives the bank's one-hot write enable and write data from a register stage.
- Supports a lock so a requester can keep the port for back-to-back multi-register writes.
- Sits between the execute/writeback stages and the register bank's en / to_dest_reg inputs.

Parameters:
- NREQ, 3, number of write requesters (2..8).
- DATA_W, 16, write data width; matches the register width.
- NREG, 8, number of registers; the index width is $clog2(NREG) = 3.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester write request.
- lock  input  NREQ  per-requester lock; meaningful only together with req.
- dest_idx  input  NREQ*3  packed destination indices; requester i uses bits [3i+2:3i].
- wdata  input  NREQ*DATA_W  packed write data; requester i uses bits [DATA_W*i+DATA_W-1:DATA_W*i].
- gnt  output  NREQ  registered one-hot grant; pulses for one cycle per accepted write.
- en  output  NREG  registered one-hot write enable to the register bank.
- to_dest_reg  output  DATA_W  registered write data to the register bank.
- busy  output  1  high while the arbiter is in state LOCKED.

Behaviour:
- Reset values: gnt=0, en=0, to_dest_reg=0, busy=0, rr_ptr=0, owner=0, state=ARB.
- Reset has priority over every other event. A reset during LOCKED returns the block to ARB and clears all outputs on the same edge.
- Handshake: a requester holds req, dest_idx, wdata and lock stable until it sees gnt[i]=1 at a rising edge. The transfer completes in that cycle. The requester may then change or drop its signals in the next cycle.
- Latency: a request sampled at edge N produces gnt[i], en=1<<dest_idx and to_dest_reg=wdata at edge N, visible during cycle N+1. The bank latches the data at edge N+1.
- en is all-zero in every cycle without a grant, so the bank never sees a multi-hot or stale enable.
- State ARB:
  - The winner is the first requester with req set, searching upward from rr_ptr and wrapping from NREQ-1 to 0.
  - On a grant, rr_ptr becomes (winner+1) mod NREQ.
  - If the winner also has lock=1: owner=winner and the state moves to LOCKED.
  - With no requests: outputs stay zero and rr_ptr is unchanged.
- State LOCKED:
  - Only owner is eligible. Other requesters get no grant even when requesting.
  - If req[owner]=1: grant owner every cycle; rr_ptr is not changed.
  - If req[owner]=1 and lock[owner]=0: this is the final write of the burst. Grant it and return to ARB.
  - If req[owner]=0: no grant, en=0, return to ARB. This is a lock abort.
- busy is 1 exactly while state=LOCKED, registered.
- gnt is at most one-hot. If multiple requesters target the same register, serialization resolves it and the last granted write wins.

Optional Feature:
- Macro: REGWR_STARVE_GUARD_EN.
- When defined:
  - Each LOCKED episode is capped at 4 consecutive grants.
  - After the 4th grant the arbiter returns to ARB regardless of lock. rr_ptr is set to (owner+1) mod NREQ.
  - The owner then rearbitrates normally; its lock is honoured again if it wins.
- When undefined: the lock duration is unbounded and there is no burst counter.

Decomposition:
- Shared package regfile_pkg:
  - constants REG_COUNT=8, REG_W=16, REG_IDX_W=3;
  - the state typedef {ARB, LOCKED};
  - a function idx_to_onehot(index) returning the NREG-bit enable.
- Sub-module rr_pick:
  - purely combinational round-robin search;
  - inputs: request vector and pointer; outputs: winner index and valid.
  - Reusable for future read-port sharing.

Test Plan:
- Reset: assert reset for 2 cycles with all req=1. Required: gnt=0, en=0, to_dest_reg=0, busy=0 throughout; first grant goes to requester 0 one edge after reset releases.
- Single write: req[1]=1, dest_idx1=5, wdata1=16'hBEEF for 1 cycle. Required: next cycle gnt=3'b010, en=8'b00100000, to_dest_reg=16'hBEEF; the cycle after, en=0.
- Round-robin: all three requesting continuously, dest_idx 0/1/2. Required: grants cycle 0,1,2,0,1,2 with en 01,02,04 repeating and no requester skipped.
- Lock burst: requester 2 issues req+lock for 3 cycles, then drops lock; requesters 0 and 1 request throughout. Required:
  - 4 consecutive grants to 2, busy=1 for 3 cycles, then grant to 0.
  - With REGWR_STARVE_GUARD_EN and a 6-cycle lock: only 4 grants to 2, then a grant to 0.
- Lock abort: the owner drops req while locked. Required: no grant and en=0 that cycle, then ARB; busy falls.
- Reset mid-burst: reset in the 2nd cycle of a lock. Required: on the next edge gnt=0, en=0, busy=0, and arbitration restarts from requester 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants, FSM state type and enable decoder for the register-bank write port.
package regfile_pkg;

  localparam int REG_COUNT = 8;
  localparam int REG_W     = 16;
  localparam int REG_IDX_W = 3;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [REG_COUNT-1:0] idx_to_onehot(input logic [REG_IDX_W-1:0] idx);
    logic [REG_COUNT-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the write requesters and the register-bank write arbiter.
interface regfile_write_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = REG_W,
  parameter int NREG   = REG_COUNT
);
  // Handshake: requester i holds req[i], lock[i], its dest_idx slice and its
  // wdata slice stable until gnt[i]=1 is sampled at a rising edge; the write
  // completes in that cycle and the requester may change or drop them after.
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           lock;
  logic [NREQ*REG_IDX_W-1:0] dest_idx;
  logic [NREQ*DATA_W-1:0]    wdata;
  logic [NREQ-1:0]           gnt;
  logic [NREG-1:0]           en;
  logic [DATA_W-1:0]         to_dest_reg;
  logic                      busy;

  modport master (
    output req, lock, dest_idx, wdata,
    input  gnt, en, to_dest_reg, busy
  );

  modport slave (
    input  req, lock, dest_idx, wdata,
    output gnt, en, to_dest_reg, busy
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          valid
);

  int j;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    j      = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        winner = PW'(j);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter with lock for the register bank's single write port.
// Define REGWR_STARVE_GUARD_EN to cap each lock episode at 4 consecutive grants.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = REG_W,
  parameter int NREG   = REG_COUNT
) (
  input  logic              clk,
  input  logic              reset,
  regfile_write_arbiter_if.slave bus,
  output arb_state_e        dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] w);
    return (w == LAST_IDX) ? '0 : w + 1'b1;
  endfunction

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     owner_q, owner_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREG-1:0]   en_q, en_d;
  logic [DATA_W-1:0] to_dest_reg_q, to_dest_reg_d;
  logic              busy_q, busy_d;
`ifdef REGWR_STARVE_GUARD_EN
  logic [2:0]        burst_cnt_q, burst_cnt_d;
`endif

  logic [PW-1:0] win_idx;
  logic          win_valid;
  logic [PW-1:0] grant_idx;
  logic          grant_valid;

  rr_pick #(.N(NREQ), .PW(PW)) u_rr_pick (
    .req    (bus.req),
    .ptr    (rr_ptr_q),
    .winner (win_idx),
    .valid  (win_valid)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    gnt_d         = '0;
    en_d          = '0;
    to_dest_reg_d = '0;
    grant_valid   = 1'b0;
    grant_idx     = win_idx;
`ifdef REGWR_STARVE_GUARD_EN
    burst_cnt_d   = burst_cnt_q;
`endif
    case (state_q)
      ARB: begin
        if (win_valid) begin
          grant_valid = 1'b1;
          grant_idx   = win_idx;
          rr_ptr_d    = next_idx(win_idx);
          if (bus.lock[win_idx]) begin
            state_d = LOCKED;
            owner_d = win_idx;
`ifdef REGWR_STARVE_GUARD_EN
            burst_cnt_d = 3'd1;
`endif
          end
        end
      end
      LOCKED: begin
        if (bus.req[owner_q]) begin
          grant_valid = 1'b1;
          grant_idx   = owner_q;
          if (!bus.lock[owner_q]) state_d = ARB;
`ifdef REGWR_STARVE_GUARD_EN
          // The 4th grant of an episode forces rearbitration starting past the owner.
          burst_cnt_d = burst_cnt_q + 3'd1;
          if (burst_cnt_q == 3'd3) begin
            state_d  = ARB;
            rr_ptr_d = next_idx(owner_q);
          end
`endif
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    if (grant_valid) begin
      gnt_d[grant_idx] = 1'b1;
      en_d             = idx_to_onehot(bus.dest_idx[REG_IDX_W*grant_idx +: REG_IDX_W]);
      to_dest_reg_d    = bus.wdata[DATA_W*grant_idx +: DATA_W];
    end
    busy_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      gnt_q         <= '0;
      en_q          <= '0;
      to_dest_reg_q <= '0;
      busy_q        <= 1'b0;
`ifdef REGWR_STARVE_GUARD_EN
      burst_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      gnt_q         <= gnt_d;
      en_q          <= en_d;
      to_dest_reg_q <= to_dest_reg_d;
      busy_q        <= busy_d;
`ifdef REGWR_STARVE_GUARD_EN
      burst_cnt_q   <= burst_cnt_d;
`endif
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.en          = en_q;
  assign bus.to_dest_reg = to_dest_reg_q;
  assign bus.busy        = busy_q;
  assign dbg_state       = state_q;

endmodule
